// File: rtl/packet_tx.sv
// Packs up to three FILTER_WIDTH words plus a routed header into one NoC packet.
// Optional packet counter output enabled by defining PACKET_TX_STATS_EN.
module packet_tx #(
    parameter  int FILTER_WIDTH = 8,
    localparam int PKT_WIDTH    = 9 + 3*FILTER_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FILTER_WIDTH-1:0] in_data,
    input  logic [1:0]              in_dest,
    input  logic                    in_type,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [PKT_WIDTH-1:0]    pkt_data,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic                    busy
`ifdef PACKET_TX_STATS_EN
    ,
    output logic [15:0]             pkt_count
`endif
);

    typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              slot_q, slot_d;
    logic [FILTER_WIDTH-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic [1:0]              dest_q, dest_d;
    logic                    type_q, type_d;
    logic [2:0]              seq_q, seq_d;
    logic [1:0]              x_hop;
    logic                    y_hop;
    logic                    accept, close, fire;

    assign accept = in_valid & in_ready;
    assign close  = accept & (in_last | (slot_q == 2'd2));
    assign fire   = pkt_valid & pkt_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (close) state_d = SEND;
            SEND: if (fire)  state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // in_ready is gated by rst so nothing is accepted while reset is held.
    always_comb begin
        in_ready  = (state_q == FILL) & ~rst;
        pkt_valid = (state_q == SEND);
        busy      = (state_q == SEND) | (slot_q != 2'd0);
    end

    // Unfilled slots stay zero because the payload is cleared on every send.
    always_comb begin
        slot_d = slot_q;
        w0_d   = w0_q;
        w1_d   = w1_q;
        w2_d   = w2_q;
        dest_d = dest_q;
        type_d = type_q;
        seq_d  = seq_q;
        if (fire) begin
            slot_d = 2'd0;
            w0_d   = '0;
            w1_d   = '0;
            w2_d   = '0;
            seq_d  = seq_q + 3'd1;
        end else if (accept) begin
            case (slot_q)
                2'd0: begin
                    w0_d   = in_data;
                    dest_d = in_dest;
                    type_d = in_type;
                end
                2'd1:    w1_d = in_data;
                default: w2_d = in_data;
            endcase
            if (!close) slot_d = slot_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= 2'd0;
            w0_q   <= '0;
            w1_q   <= '0;
            w2_q   <= '0;
            dest_q <= 2'd0;
            type_q <= 1'b0;
            seq_q  <= 3'd0;
        end else begin
            slot_q <= slot_d;
            w0_q   <= w0_d;
            w1_q   <= w1_d;
            w2_q   <= w2_d;
            dest_q <= dest_d;
            type_q <= type_d;
            seq_q  <= seq_d;
        end
    end

    always_comb begin
        x_hop = 2'b10;
        y_hop = 1'b1;
        case (dest_q)
            2'd0: begin x_hop = 2'b10; y_hop = 1'b1; end
            2'd1: begin x_hop = 2'b00; y_hop = 1'b1; end
            2'd2: begin x_hop = 2'b11; y_hop = 1'b0; end
            default: begin x_hop = 2'b10; y_hop = 1'b0; end
        endcase
    end

    assign pkt_data = {w2_q, w1_q, w0_q, seq_q, type_q, y_hop, x_hop, 2'b11};

`ifdef PACKET_TX_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

    assign pkt_count = cnt_q;
`endif

endmodule

// File: tb/tb_packet_tx.sv
// Self-checking bench for packet_tx: directed vector table, corner sequences,
// and a randomized run against a queue-based packet model.
module tb_packet_tx;

    localparam int FW = 8;
    localparam int PW = 9 + 3*FW;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_type;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] pkt_data;
    logic          pkt_valid;
    logic          pkt_ready;
    logic          busy;
`ifdef PACKET_TX_STATS_EN
    logic [15:0]   pkt_count;
`endif

    packet_tx #(.FILTER_WIDTH(FW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_dest(in_dest), .in_type(in_type),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .busy(busy)
`ifdef PACKET_TX_STATS_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0][FW-1:0] w;
        int                 n;
        logic [1:0]         dest0;
        logic [1:0]         dest_rest;
        logic               typ;
        logic [PW-1:0]      exp;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [FW-1:0] d, input logic [1:0] dst, input logic t,
                       input logic l, input logic v);
        in_data  = d;
        in_dest  = dst;
        in_type  = t;
        in_last  = l;
        in_valid = v;
    endtask

    // Reference packet assembled directly from the documented layout and route table.
    function automatic logic [PW-1:0] mk_pkt(input logic [FW-1:0] w0, input logic [FW-1:0] w1,
                                             input logic [FW-1:0] w2, input int seq,
                                             input logic t, input logic [1:0] dst);
        logic [1:0] x;
        logic       y;
        case (dst)
            2'd0: begin x = 2'b10; y = 1'b1; end
            2'd1: begin x = 2'b00; y = 1'b1; end
            2'd2: begin x = 2'b11; y = 1'b0; end
            default: begin x = 2'b10; y = 1'b0; end
        endcase
        return {w2, w1, w0, 3'(seq % 8), t, y, x, 2'b11};
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        pkt_ready = 1'b0;
        drv('0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic send3(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic [FW-1:0] c,
                         input logic [1:0] dst, input logic t);
        drv(a, dst, t, 1'b0, 1'b1); tick();
        drv(b, dst, t, 1'b0, 1'b1); tick();
        drv(c, dst, t, 1'b0, 1'b1); tick();
        drv('0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [PW-1:0] exp_q[$];
    logic [FW-1:0] gw [3];
    int            grp_n, seq_m, n_hs;
    logic [1:0]    g_dest;
    logic          g_type;

    initial begin
        tbl[0] = '{w:{8'h33, 8'h22, 8'h11}, n:3, dest0:2'd0, dest_rest:2'd0, typ:1'b0,
                   exp:{8'h33, 8'h22, 8'h11, 3'd0, 1'b0, 1'b1, 2'b10, 2'b11}};
        tbl[1] = '{w:{8'h00, 8'h00, 8'hAA}, n:1, dest0:2'd2, dest_rest:2'd2, typ:1'b1,
                   exp:{8'h00, 8'h00, 8'hAA, 3'd1, 1'b1, 1'b0, 2'b11, 2'b11}};
        tbl[2] = '{w:{8'h03, 8'h02, 8'h01}, n:3, dest0:2'd1, dest_rest:2'd3, typ:1'b0,
                   exp:{8'h03, 8'h02, 8'h01, 3'd2, 1'b0, 1'b1, 2'b00, 2'b11}};
        tbl[3] = '{w:{8'h00, 8'hC3, 8'h5A}, n:2, dest0:2'd3, dest_rest:2'd0, typ:1'b1,
                   exp:{8'h00, 8'hC3, 8'h5A, 3'd3, 1'b1, 1'b0, 2'b10, 2'b11}};
        tbl[4] = '{w:{8'hFF, 8'h81, 8'h7E}, n:3, dest0:2'd1, dest_rest:2'd2, typ:1'b1,
                   exp:{8'hFF, 8'h81, 8'h7E, 3'd4, 1'b1, 1'b1, 2'b00, 2'b11}};

        do_reset();

        // Directed table; later words carry a different dest/type that must be ignored.
        pkt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                chk($sformatf("tbl%0d_w%0d_ready", i, k), 64'(in_ready), 64'd1);
                drv(tbl[i].w[k], (k == 0) ? tbl[i].dest0 : tbl[i].dest_rest,
                    (k == 0) ? tbl[i].typ : ~tbl[i].typ, (k == tbl[i].n - 1), 1'b1);
                tick();
                chk($sformatf("tbl%0d_w%0d_busy", i, k), 64'(busy), 64'd1);
            end
            drv('0, 2'd0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 64'(pkt_valid), 64'd1);
            chk($sformatf("tbl%0d_data", i), 64'(pkt_data), 64'(tbl[i].exp));
            tick();
            chk($sformatf("tbl%0d_valid_off", i), 64'(pkt_valid), 64'd0);
            chk($sformatf("tbl%0d_back_fill", i), 64'(in_ready), 64'd1);
            chk($sformatf("tbl%0d_idle", i), 64'(busy), 64'd0);
        end

        // Backpressure: packet must hold while pkt_ready is low.
        pkt_ready = 1'b0;
        send3(8'h10, 8'h20, 8'h30, 2'd3, 1'b0);
        drv(8'hEE, 2'd0, 1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_valid", c), 64'(pkt_valid), 64'd1);
            chk($sformatf("stall%0d_ready", c), 64'(in_ready), 64'd0);
            chk($sformatf("stall%0d_data", c), 64'(pkt_data),
                64'(mk_pkt(8'h10, 8'h20, 8'h30, 5, 1'b0, 2'd3)));
            tick();
        end
        drv('0, 2'd0, 1'b0, 1'b0, 1'b0);
        pkt_ready = 1'b1;
        tick();
        chk("stall_release_valid", 64'(pkt_valid), 64'd0);
        chk("stall_release_ready", 64'(in_ready), 64'd1);

        // Nine back-to-back packets: seq wraps 7 -> 0.
        do_reset();
        pkt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send3(8'(i), 8'(i + 16), 8'(i + 32), 2'(i), 1'(i));
            chk($sformatf("b2b%0d_valid", i), 64'(pkt_valid), 64'd1);
            chk($sformatf("b2b%0d_data", i), 64'(pkt_data),
                64'(mk_pkt(8'(i), 8'(i + 16), 8'(i + 32), i, 1'(i), 2'(i))));
            tick();
        end
`ifdef PACKET_TX_STATS_EN
        chk("b2b_pkt_count", 64'(pkt_count), 64'd9);
`endif

        // Mid-group reset drops the partial group.
        do_reset();
        pkt_ready = 1'b1;
        drv(8'h44, 2'd2, 1'b1, 1'b0, 1'b1); tick();
        drv(8'h55, 2'd2, 1'b1, 1'b0, 1'b1); tick();
        chk("midrst_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        drv('0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("midrst_novalid%0d", c), 64'(pkt_valid), 64'd0);
            tick();
        end
        send3(8'h66, 8'h77, 8'h88, 2'd0, 1'b0);
        chk("midrst_next_valid", 64'(pkt_valid), 64'd1);
        chk("midrst_next_data", 64'(pkt_data), 64'(mk_pkt(8'h66, 8'h77, 8'h88, 0, 1'b0, 2'd0)));
        tick();

        // Randomized run against the queue model.
        do_reset();
        grp_n = 0; seq_m = 0; n_hs = 0;
        gw[0] = '0; gw[1] = '0; gw[2] = '0;
        g_dest = 2'd0; g_type = 1'b0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            logic pr;
            chk("rnd_in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
            chk("rnd_busy", 64'(busy), 64'((exp_q.size() != 0) || (grp_n != 0)));
            chk("rnd_pkt_valid", 64'(pkt_valid), 64'(exp_q.size() != 0));
            pr = (cyc >= 680) ? 1'b1 : 1'($urandom_range(0, 1));
            pkt_ready = pr;
            if (exp_q.size() != 0) begin
                chk("rnd_pkt_data", 64'(pkt_data), 64'(exp_q[0]));
                if (pr) begin
                    void'(exp_q.pop_front());
                    n_hs++;
                end
                drv(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else if (cyc < 680 && $urandom_range(0, 3) != 0) begin
                logic [FW-1:0] w;
                logic [1:0]    d;
                logic          t, l;
                w = 8'($urandom); d = 2'($urandom); t = 1'($urandom);
                l = ($urandom_range(0, 3) == 0);
                if (grp_n == 0) begin g_dest = d; g_type = t; end
                gw[grp_n] = w;
                grp_n++;
                if (l || grp_n == 3) begin
                    exp_q.push_back(mk_pkt(gw[0], gw[1], gw[2], seq_m, g_type, g_dest));
                    seq_m++;
                    grp_n = 0;
                    gw[0] = '0; gw[1] = '0; gw[2] = '0;
                end
                drv(w, d, t, l, 1'b1);
            end else begin
                drv(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            tick();
        end
        chk("rnd_drained", 64'(exp_q.size()), 64'd0);
`ifdef PACKET_TX_STATS_EN
        chk("rnd_pkt_count", 64'(pkt_count), 64'(n_hs));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
